// File: rtl/word_match_if.sv
// Character-stream bus between the word source and word_match_generator.
// The master offers target and guess characters; the slave reports readiness
// and the per-guess match flags.
interface word_match_if #(
  parameter int CHAR_W = 8
);
  logic              tgt_valid;
  logic [CHAR_W-1:0] tgt_char;
  logic              guess_valid;
  logic [CHAR_W-1:0] guess_char;
  logic              in_ready;
  logic              target_loaded;
  logic              result_valid;
  logic              full_match;
  logic              first_half;
  logic              second_half;
  logic              flag;

  modport master (
    output tgt_valid, tgt_char, guess_valid, guess_char,
    input  in_ready, target_loaded, result_valid,
           full_match, first_half, second_half, flag
  );

  modport slave (
    input  tgt_valid, tgt_char, guess_valid, guess_char,
    output in_ready, target_loaded, result_valid,
           full_match, first_half, second_half, flag
  );
endinterface

// File: rtl/word_match_generator.sv
// Serial word comparator: stores a target word one character at a time, then
// compares guess words against it and reports full/half matches plus a
// first-attempt flag with a one-cycle result strobe.
module word_match_generator #(
  parameter int CHARS  = 8,
  parameter int CHAR_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  word_match_if.slave bus
);
  localparam int IDX_W = $clog2(CHARS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARS - 1);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(CHARS / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [IDX_W-1:0]              r_idx;
  logic [CHARS-1:0][CHAR_W-1:0]  r_tgt;
  logic                          r_miss_lo;
  logic                          r_miss_hi;
  logic                          r_first_attempt;
  logic                          r_target_loaded;
  logic                          r_full_match;
  logic                          r_first_half;
  logic                          r_second_half;
  logic                          r_flag;

  logic                          w_in_ready;
  logic                          w_tgt_wr;
  logic                          w_cmp;
  logic [IDX_W-1:0]              w_cur_idx;
  logic                          w_word_end;
  logic                          w_mismatch;
  logic                          w_miss_lo_new;
  logic                          w_miss_hi_new;

  // Acceptance and datapath strobes shared by the FSM and the registers.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_in_ready    = (r_state != S_DONE);
    w_tgt_wr      = 1'b0;
    w_cmp         = 1'b0;
    // A word always starts at index 0, whatever r_idx holds on entry.
    w_cur_idx     = (r_state == S_LOAD || r_state == S_COMPARE) ? r_idx : '0;
    w_word_end    = (w_cur_idx == LAST_IDX);
    w_mismatch    = (bus.guess_char != r_tgt[w_cur_idx]);
    // Miss flags restart when a new guess begins from READY.
    w_miss_lo_new = ((r_state == S_READY) ? 1'b0 : r_miss_lo)
                    | (w_mismatch & (w_cur_idx < HALF_IDX));
    w_miss_hi_new = ((r_state == S_READY) ? 1'b0 : r_miss_hi)
                    | (w_mismatch & (w_cur_idx >= HALF_IDX));
    case (r_state)
      S_IDLE, S_LOAD: w_tgt_wr = bus.tgt_valid;
      S_READY: begin
        // Target reload wins over a simultaneous guess character.
        w_tgt_wr = bus.tgt_valid;
        w_cmp    = !bus.tgt_valid && bus.guess_valid;
      end
      S_COMPARE: w_cmp = bus.guess_valid;
      default: ;
    endcase
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_tgt_wr) w_state_next = S_LOAD;
      S_LOAD:    if (w_tgt_wr && w_word_end) w_state_next = S_READY;
      S_READY: begin
        if (w_tgt_wr)   w_state_next = S_LOAD;
        else if (w_cmp) w_state_next = S_COMPARE;
      end
      S_COMPARE: if (w_cmp && w_word_end) w_state_next = S_DONE;
      S_DONE:    w_state_next = S_READY;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Index counter, target storage, miss tracking and registered result flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx           <= '0;
      // NOTE: the target store is cleared on reset on purpose; a stale word
      // must never be compared after a reset, even though nothing reads it
      // before a reload.
      r_tgt           <= '0;
      r_miss_lo       <= 1'b0;
      r_miss_hi       <= 1'b0;
      r_first_attempt <= 1'b0;
      r_target_loaded <= 1'b0;
      r_full_match    <= 1'b0;
      r_first_half    <= 1'b0;
      r_second_half   <= 1'b0;
      r_flag          <= 1'b0;
    end else begin
      if (w_tgt_wr || w_cmp)
        r_idx <= w_word_end ? '0 : w_cur_idx + 1'b1;
      if (w_tgt_wr) begin
        r_tgt[w_cur_idx] <= bus.tgt_char;
        r_target_loaded  <= w_word_end;
        if (w_word_end) r_first_attempt <= 1'b1;
      end
      if (w_cmp) begin
        r_miss_lo <= w_miss_lo_new;
        r_miss_hi <= w_miss_hi_new;
        if (w_word_end) begin
          r_first_half    <= !w_miss_lo_new;
          r_second_half   <= !w_miss_hi_new;
          r_full_match    <= !w_miss_lo_new && !w_miss_hi_new;
          r_flag          <= r_first_attempt;
          r_first_attempt <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.target_loaded = r_target_loaded;
  assign bus.result_valid  = (r_state == S_DONE);
  assign bus.full_match    = r_full_match;
  assign bus.first_half    = r_first_half;
  assign bus.second_half   = r_second_half;
  assign bus.flag          = r_flag;
endmodule

// File: tb/tb_word_match_generator.sv
// Self-checking bench for word_match_generator: directed words with literal
// expectations, plus a word-level reference model compared every cycle.
module tb_word_match_generator;
  localparam int CHARS  = 8;
  localparam int CHAR_W = 8;

  logic clk;
  logic rst;
  word_match_if #(.CHAR_W(CHAR_W)) bus ();

  word_match_generator #(.CHARS(CHARS), .CHAR_W(CHAR_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: collects whole words in queues and scores a guess only
  // once all of its characters have arrived.
  logic [CHAR_W-1:0] tq[$];
  logic [CHAR_W-1:0] gq[$];
  logic [CHAR_W-1:0] m_target [CHARS];
  bit m_loaded, m_done, m_first;
  bit m_fm, m_fh, m_sh, m_fl;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tq.delete();
      gq.delete();
      for (int i = 0; i < CHARS; i++) m_target[i] = '0;
      m_loaded = 0; m_done = 0; m_first = 0;
      m_fm = 0; m_fh = 0; m_sh = 0; m_fl = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_loaded) begin
      if (bus.tgt_valid) begin
        tq.push_back(bus.tgt_char);
        if (tq.size() == CHARS) begin
          for (int i = 0; i < CHARS; i++) m_target[i] = tq[i];
          tq.delete();
          m_loaded = 1;
          m_first  = 1;
        end
      end
    end else if (gq.size() == 0 && bus.tgt_valid) begin
      m_loaded = 0;
      tq.push_back(bus.tgt_char);
    end else if (bus.guess_valid) begin
      gq.push_back(bus.guess_char);
      if (gq.size() == CHARS) begin
        int lo_bad, hi_bad;
        lo_bad = 0; hi_bad = 0;
        for (int i = 0; i < CHARS; i++)
          if (gq[i] != m_target[i]) begin
            if (i < CHARS / 2) lo_bad++;
            else               hi_bad++;
          end
        m_fh = (lo_bad == 0);
        m_sh = (hi_bad == 0);
        m_fm = m_fh && m_sh;
        m_fl = m_first;
        m_first = 0;
        m_done = 1;
        gq.delete();
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_in_ready",      bus.in_ready,      !m_done);
    check("m_target_loaded", bus.target_loaded, m_loaded);
    check("m_result_valid",  bus.result_valid,  m_done);
    check("m_full_match",    bus.full_match,    m_fm);
    check("m_first_half",    bus.first_half,    m_fh);
    check("m_second_half",   bus.second_half,   m_sh);
    check("m_flag",          bus.flag,          m_fl);
  end

  // Drive characters first..last of word w (index 0 in the top byte); a set
  // gaps[i] inserts one idle cycle before character i. Starts and ends on a
  // falling edge; on return the last character was taken on the edge just past.
  task automatic send(input bit is_tgt, input logic [8*CHARS-1:0] w,
                      input logic [CHARS-1:0] gaps, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (gaps[i]) begin
        bus.tgt_valid = 1'b0; bus.guess_valid = 1'b0;
        @(negedge clk);
      end
      if (is_tgt) begin
        bus.tgt_valid = 1'b1; bus.tgt_char = w[8*(CHARS-1-i) +: 8];
      end else begin
        bus.guess_valid = 1'b1; bus.guess_char = w[8*(CHARS-1-i) +: 8];
      end
      @(negedge clk);
    end
    bus.tgt_valid = 1'b0; bus.guess_valid = 1'b0;
  endtask

  // Complete guess followed by literal checks in the result cycle, then one
  // more cycle so the DUT is back in READY.
  task automatic guess(input string tag, input logic [8*CHARS-1:0] w,
                       input logic [CHARS-1:0] gaps,
                       input bit fm, input bit fh, input bit sh, input bit fl);
    send(0, w, gaps, 0, CHARS - 1);
    check({tag, "_rv"}, bus.result_valid, 1'b1);
    check({tag, "_rdy"}, bus.in_ready, 1'b0);
    check({tag, "_fm"}, bus.full_match, fm);
    check({tag, "_fh"}, bus.first_half, fh);
    check({tag, "_sh"}, bus.second_half, sh);
    check({tag, "_fl"}, bus.flag, fl);
    @(negedge clk);
    check({tag, "_rv_off"}, bus.result_valid, 1'b0);
  endtask

  logic [8*CHARS-1:0] w_abc, w_hgf, w_lo_ok, w_hi_ok, w_last_bad;

  initial begin
    w_abc      = "ABCDEFGH";
    w_hgf      = "HGFEDCBA";
    w_lo_ok    = "ABCDxxxx";
    w_hi_ok    = "xxxxEFGH";
    w_last_bad = "ABCDEFGx";
    bus.tgt_valid = 1'b0; bus.tgt_char = '0;
    bus.guess_valid = 1'b0; bus.guess_char = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdy", bus.in_ready, 1'b1);
    check("rst_tl",  bus.target_loaded, 1'b0);
    check("rst_rv",  bus.result_valid, 1'b0);
    check("rst_fm",  bus.full_match, 1'b0);
    check("rst_fl",  bus.flag, 1'b0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Guesses offered before any target are ignored.
    send(0, w_abc, '0, 0, CHARS - 1);
    check("idle_tl", bus.target_loaded, 1'b0);

    send(1, w_abc, '0, 0, CHARS - 1);
    check("load_tl", bus.target_loaded, 1'b1);
    guess("g1", w_abc, '0, 1, 1, 1, 1);
    guess("g2", w_abc, '0, 1, 1, 1, 0);
    guess("g3", w_lo_ok, '0, 0, 1, 0, 0);
    guess("g4", w_hi_ok, '0, 0, 0, 1, 0);
    guess("g5", w_last_bad, 8'b1010_0110, 0, 1, 0, 0);

    // Both valids in READY: reload starts, guess character is dropped.
    bus.tgt_valid = 1'b1; bus.tgt_char = "H";
    bus.guess_valid = 1'b1; bus.guess_char = "A";
    @(negedge clk);
    bus.tgt_valid = 1'b0; bus.guess_valid = 1'b0;
    check("reload_tl", bus.target_loaded, 1'b0);
    check("reload_rv", bus.result_valid, 1'b0);
    check("reload_fm_held", bus.full_match, 1'b0);
    send(1, w_hgf, 8'b0001_0000, 1, CHARS - 1);
    check("reload_done_tl", bus.target_loaded, 1'b1);
    guess("g6", w_hgf, '0, 1, 1, 1, 1);

    // Reset in the middle of a guess.
    send(0, w_hgf, '0, 0, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rdy", bus.in_ready, 1'b1);
    check("mid_rst_tl",  bus.target_loaded, 1'b0);
    check("mid_rst_fm",  bus.full_match, 1'b0);
    check("mid_rst_fh",  bus.first_half, 1'b0);
    check("mid_rst_sh",  bus.second_half, 1'b0);
    check("mid_rst_fl",  bus.flag, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    send(0, w_hgf, '0, 0, CHARS - 1);
    check("post_rst_rv", bus.result_valid, 1'b0);
    check("post_rst_tl", bus.target_loaded, 1'b0);
    send(1, w_hgf, '0, 0, CHARS - 1);
    guess("g7", w_hgf, '0, 1, 1, 1, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
